// File: rtl/mesh_ingress_injector.sv
`default_nettype none
// ============================================================================
// Module      : mesh_ingress_injector
// Description : Pops tagged words from the scratchpad ingress FIFOs, drops
//               words whose packet ID does not match (when filtering), holds
//               accepted words in a 2-entry skid buffer per port and injects
//               them into the edge PE links over valid/ready. Reports done
//               once every port has delivered its programmed word count.
// Revision    : 1.0 - initial release
// ============================================================================
module mesh_ingress_injector #(
    parameter int NUM_INGRESS_PE = 2,
    parameter int FIFO_WIDTH     = 36,
    parameter int DBUS_WIDTH     = 32,
    parameter int BANK_SIZE      = 512,
    parameter int DROP_CW        = 8
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start,
    input  logic [$clog2(BANK_SIZE):0]           cfg_num_words,
    input  logic                                 cfg_filter_en,
    input  logic [3:0]                           cfg_pkt_id,
    output logic [NUM_INGRESS_PE-1:0]            ingress_fifo_dequeue,
    input  logic [NUM_INGRESS_PE*FIFO_WIDTH-1:0] ingress_fifo_rdata,
    input  logic [NUM_INGRESS_PE-1:0]            ingress_fifo_empty,
    output logic [NUM_INGRESS_PE-1:0]            pe_valid,
    output logic [NUM_INGRESS_PE*DBUS_WIDTH-1:0] pe_data,
    input  logic [NUM_INGRESS_PE-1:0]            pe_ready,
    output logic [NUM_INGRESS_PE*DROP_CW-1:0]    drop_count,
    output logic                                 busy,
    output logic                                 done
);

    localparam int c_CW = $clog2(BANK_SIZE) + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [c_CW-1:0]   r_target;
    logic              r_filter_en;
    logic [3:0]        r_pkt_id;
    logic              w_start_ok;
    logic              w_arm;
    logic              w_in_run;
    logic [NUM_INGRESS_PE-1:0] w_port_met;
    logic [NUM_INGRESS_PE-1:0] w_buf_empty;

    assign w_in_run = (r_state == S_RUN);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Configuration is captured on any accepted start, including zero-length runs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_target    <= '0;
            r_filter_en <= 1'b0;
            r_pkt_id    <= '0;
        end else if (w_start_ok) begin
            r_target    <= cfg_num_words;
            r_filter_en <= cfg_filter_en;
            r_pkt_id    <= cfg_pkt_id;
        end
    end

    // Next-state and status decode; status is forced low while reset is held
    always_comb begin
        w_state_nxt = r_state;
        w_start_ok  = 1'b0;
        w_arm       = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                done = (r_state == S_DONE) && !rst;
                if (start) begin
                    w_start_ok = 1'b1;
                    if (cfg_num_words != '0) begin
                        w_arm       = 1'b1;
                        w_state_nxt = S_RUN;
                    end else begin
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_RUN: begin
                busy = !rst;
                if (&w_port_met) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                busy = !rst;
                // Dequeues only happen in RUN, so no push can be pending here
                if (&w_buf_empty) begin
                    w_state_nxt = S_DONE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_INGRESS_PE; gi++) begin : g_port
            localparam logic [c_CW-1:0]    c_ACC_ONE  = 1;
            localparam logic [DROP_CW-1:0] c_DROP_ONE = 1;
            localparam logic [DROP_CW-1:0] c_DROP_MAX = '1;

            logic [c_CW-1:0]       r_acc_cnt;
            logic [DROP_CW-1:0]    r_drop_cnt;
            logic [1:0]            r_buf_cnt;
            logic [DBUS_WIDTH-1:0] r_slot0;
            logic [DBUS_WIDTH-1:0] r_slot1;
            logic [FIFO_WIDTH-1:0] w_word;
            logic [DBUS_WIDTH-1:0] w_payload;
            logic                  w_deq;
            logic                  w_drop;
            logic                  w_push;
            logic                  w_pop;

            assign w_word    = ingress_fifo_rdata[gi*FIFO_WIDTH +: FIFO_WIDTH];
            assign w_payload = w_word[DBUS_WIDTH-1:0];
            // No bypass: a full buffer blocks the pop even if the PE is ready
            assign w_deq     = !rst && w_in_run && !ingress_fifo_empty[gi] &&
                               (r_buf_cnt < 2'd2) && (r_acc_cnt < r_target);
            assign w_drop    = w_deq && r_filter_en &&
                               (w_word[FIFO_WIDTH-1 -: 4] != r_pkt_id);
            assign w_push    = w_deq && !w_drop;
            assign w_pop     = (r_buf_cnt != 2'd0) && pe_ready[gi];

            assign ingress_fifo_dequeue[gi]              = w_deq;
            assign pe_valid[gi]                          = !rst && (r_buf_cnt != 2'd0);
            assign pe_data[gi*DBUS_WIDTH +: DBUS_WIDTH]  = r_slot0;
            assign drop_count[gi*DROP_CW +: DROP_CW]     = r_drop_cnt;
            assign w_port_met[gi]                        = (r_acc_cnt == r_target);
            assign w_buf_empty[gi]                       = (r_buf_cnt == 2'd0);

            // Accept and drop counters, cleared when a non-empty run is armed
            always_ff @(posedge clk) begin
                if (rst || w_arm) begin
                    r_acc_cnt  <= '0;
                    r_drop_cnt <= '0;
                end else begin
                    if (w_push) begin
                        r_acc_cnt <= r_acc_cnt + c_ACC_ONE;
                    end
                    if (w_drop && (r_drop_cnt != c_DROP_MAX)) begin
                        r_drop_cnt <= r_drop_cnt + c_DROP_ONE;
                    end
                end
            end

            // Two-entry skid buffer; slot0 is always the head presented to the PE
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_buf_cnt <= 2'd0;
                    r_slot0   <= '0;
                    r_slot1   <= '0;
                end else begin
                    case ({w_push, w_pop})
                        2'b10: begin
                            if (r_buf_cnt == 2'd0) begin
                                r_slot0 <= w_payload;
                            end else begin
                                r_slot1 <= w_payload;
                            end
                            r_buf_cnt <= r_buf_cnt + 2'd1;
                        end
                        2'b01: begin
                            r_slot0   <= r_slot1;
                            r_buf_cnt <= r_buf_cnt - 2'd1;
                        end
                        2'b11: begin
                            // Push only happens below full, so occupancy is 1 here
                            r_slot0 <= w_payload;
                        end
                        default: begin
                        end
                    endcase
                end
            end
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_mesh_ingress_injector.sv
`default_nettype none
// ============================================================================
// Module      : tb_mesh_ingress_injector
// Description : Directed scoreboard bench for mesh_ingress_injector. A FIFO
//               model feeds each ingress port, stimulus pushes expected PE
//               payloads into per-port queues and a monitor compares every
//               link transfer against them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mesh_ingress_injector;

    localparam int NP = 2;
    localparam int FW = 36;
    localparam int DW = 32;
    localparam int DC = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [9:0]       cfg_num_words;
    logic             cfg_filter_en;
    logic [3:0]       cfg_pkt_id;
    logic [NP-1:0]    deq;
    logic [NP*FW-1:0] fdata = '0;
    logic [NP-1:0]    fempty = '1;
    logic [NP-1:0]    pe_valid;
    logic [NP*DW-1:0] pe_data;
    logic [NP-1:0]    pe_ready;
    logic [NP*DC-1:0] drop_count;
    logic             busy;
    logic             done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [FW-1:0] fq[NP][$];
    logic [DW-1:0] exp_q[NP][$];
    int            hold[NP];
    logic          pend[NP];
    int            deq_cnt[NP];
    int            xfer_cnt[NP];
    int            first_deq[NP];
    int            last_deq[NP];
    int            first_val[NP];
    int            last_xfer[NP];
    logic          stalled[NP];
    logic [DW-1:0] held[NP];

    mesh_ingress_injector dut (
        .clk                  (clk),
        .rst                  (rst),
        .start                (start),
        .cfg_num_words        (cfg_num_words),
        .cfg_filter_en        (cfg_filter_en),
        .cfg_pkt_id           (cfg_pkt_id),
        .ingress_fifo_dequeue (deq),
        .ingress_fifo_rdata   (fdata),
        .ingress_fifo_empty   (fempty),
        .pe_valid             (pe_valid),
        .pe_data              (pe_data),
        .pe_ready             (pe_ready),
        .drop_count           (drop_count),
        .busy                 (busy),
        .done                 (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic refresh();
        for (int p = 0; p < NP; p++) begin
            fdata[p*FW +: FW] = (fq[p].size() > 0) ? fq[p][0] : '0;
            fempty[p]         = (fq[p].size() == 0) || (hold[p] > 0);
        end
    endtask

    // FIFO model: pops what the DUT dequeued on the previous edge
    always begin
        @(posedge clk);
        #1;
        for (int p = 0; p < NP; p++) begin
            if (pend[p] && fq[p].size() > 0) void'(fq[p].pop_front());
            pend[p] = 1'b0;
            if (hold[p] > 0) hold[p]--;
        end
        refresh();
    end

    // Monitor: dequeue bookkeeping, link stability and scoreboard compare
    always @(negedge clk) begin
        for (int p = 0; p < NP; p++) begin
            pend[p] = deq[p];
            if (deq[p]) begin
                if (first_deq[p] < 0) first_deq[p] = cyc;
                last_deq[p] = cyc;
                deq_cnt[p]++;
            end
            if (!pe_valid[p]) begin
                stalled[p] = 1'b0;
            end else begin
                if (first_val[p] < 0) first_val[p] = cyc;
                if (stalled[p]) check($sformatf("stable_p%0d", p), pe_data[p*DW +: DW], held[p]);
                if (pe_ready[p]) begin
                    stalled[p] = 1'b0;
                    xfer_cnt[p]++;
                    last_xfer[p] = cyc;
                    if (exp_q[p].size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_xfer_p%0d actual=%0h required=none", p, pe_data[p*DW +: DW]);
                    end else begin
                        check($sformatf("sb_data_p%0d", p), pe_data[p*DW +: DW], exp_q[p].pop_front());
                    end
                end else begin
                    stalled[p] = 1'b1;
                    held[p]    = pe_data[p*DW +: DW];
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_stats();
        for (int p = 0; p < NP; p++) begin
            deq_cnt[p] = 0; xfer_cnt[p] = 0; first_deq[p] = -1; last_deq[p] = -1;
            first_val[p] = -1; last_xfer[p] = -1;
        end
    endtask

    task automatic load(input int p, input logic [3:0] id, input logic [31:0] pl, input bit expect_it);
        fq[p].push_back({id, pl});
        if (expect_it) exp_q[p].push_back(pl);
    endtask

    task automatic do_start(input logic [9:0] n, input logic fen, input logic [3:0] pid);
        cfg_num_words = n;
        cfg_filter_en = fen;
        cfg_pkt_id    = pid;
        start         = 1'b1;
        tick();
        start         = 1'b0;
    endtask

    task automatic wait_done(input int max, output int dcyc);
        bit got = 0;
        dcyc = -1;
        for (int i = 0; i < max && !got; i++) begin
            @(negedge clk);
            if (done) begin
                got  = 1;
                dcyc = cyc;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL wait_done actual=timeout required=done");
        end
        tick();
    endtask

    initial begin
        int dc;
        bit got;
        for (int p = 0; p < NP; p++) begin
            hold[p] = 0; pend[p] = 1'b0; stalled[p] = 1'b0; held[p] = '0;
        end
        clear_stats();
        rst = 1'b1; start = 1'b0; cfg_num_words = '0; cfg_filter_en = 1'b0;
        cfg_pkt_id = '0; pe_ready = '0;
        repeat (2) tick();
        @(negedge clk);
        check("rst_deq", 64'(deq), 0);
        check("rst_valid", 64'(pe_valid), 0);
        check("rst_busy", 64'(busy), 0);
        check("rst_done", 64'(done), 0);
        check("rst_drop", 64'(drop_count), 0);
        tick();
        rst = 1'b0;
        tick();

        // T1: 4 matching words per port, one extra word must stay queued
        clear_stats();
        for (int i = 0; i < 5; i++) begin
            load(0, 4'h4, 32'h1111_0001 + i, i < 4);
            load(1, 4'h4, 32'h2222_0001 + i, i < 4);
        end
        pe_ready = 2'b11;
        do_start(10'd4, 1'b1, 4'h4);
        wait_done(40, dc);
        check("t1_deq_cnt", 64'(deq_cnt[0]), 4);
        check("t1_deq_consec", 64'(last_deq[0] - first_deq[0]), 3);
        check("t1_valid_lat", 64'(first_val[0] - first_deq[0]), 1);
        check("t1_xfer_cnt", 64'(xfer_cnt[0]), 4);
        check("t1_done_lat", 64'(dc - last_xfer[0]), 2);
        check("t1_drop", 64'(drop_count), 0);
        check("t1_left_in_fifo", 64'(fq[0].size()), 1);
        fq[0].delete(); fq[1].delete();

        // T2: filter on ID 3, port 0 sees IDs 3,5,3,5,3
        clear_stats();
        load(0, 4'h3, 32'hA000_0000, 1); load(0, 4'h5, 32'hA000_0001, 0);
        load(0, 4'h3, 32'hA000_0002, 1); load(0, 4'h5, 32'hA000_0003, 0);
        load(0, 4'h3, 32'hA000_0004, 1);
        for (int i = 0; i < 3; i++) load(1, 4'h3, 32'hB000_0000 + i, 1);
        do_start(10'd3, 1'b1, 4'h3);
        wait_done(40, dc);
        check("t2_drop_p0", 64'(drop_count[7:0]), 2);
        check("t2_drop_p1", 64'(drop_count[15:8]), 0);
        check("t2_xfer_p0", 64'(xfer_cnt[0]), 3);
        check("t2_done", 64'(done), 1);

        // T3: PE stalled for 5 cycles, only two words may be popped
        clear_stats();
        pe_ready = 2'b00;
        for (int i = 0; i < 6; i++) begin
            load(0, 4'h0, 32'hC000_0010 + i, 1);
            load(1, 4'h0, 32'hD000_0020 + i, 1);
        end
        do_start(10'd6, 1'b0, 4'h0);
        repeat (5) tick();
        check("t3_stall_deq_p0", 64'(deq_cnt[0]), 2);
        check("t3_stall_deq_p1", 64'(deq_cnt[1]), 2);
        pe_ready = 2'b11;
        wait_done(60, dc);
        check("t3_xfer_p0", 64'(xfer_cnt[0]), 6);
        check("t3_xfer_p1", 64'(xfer_cnt[1]), 6);

        // T6: reset mid-run with one word buffered on port 0 and one drop
        clear_stats();
        pe_ready = 2'b00;
        load(0, 4'h1, 32'hE000_0000, 0);
        for (int i = 1; i < 4; i++) load(0, 4'h7, 32'hE000_0000 + i, 0);
        for (int i = 0; i < 4; i++) load(1, 4'h7, 32'hF000_0000 + i, 0);
        do_start(10'd4, 1'b1, 4'h7);
        tick(); tick();
        @(negedge clk);
        check("t6_pre_drop", 64'(drop_count[7:0]), 1);
        check("t6_pre_valid", 64'(pe_valid), 2'b11);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        fq[0].delete(); fq[1].delete();
        @(negedge clk);
        check("t6_deq", 64'(deq), 0);
        check("t6_valid", 64'(pe_valid), 0);
        check("t6_busy", 64'(busy), 0);
        check("t6_done", 64'(done), 0);
        check("t6_drop", 64'(drop_count), 0);
        tick();
        pe_ready = 2'b11;
        repeat (4) tick();
        check("t6_flushed", 64'(xfer_cnt[0] + xfer_cnt[1]), 0);

        // T4: zero-length run from IDLE
        clear_stats();
        for (int i = 0; i < 3; i++) load(0, 4'h0, 32'h0BAD_0000 + i, 0);
        @(negedge clk);
        check("t4_done_before", 64'(done), 0);
        start = 1'b1; cfg_num_words = '0; cfg_filter_en = 1'b0;
        @(posedge clk); #1; start = 1'b0;
        @(negedge clk);
        check("t4_done_next", 64'(done), 1);
        check("t4_busy", 64'(busy), 0);
        repeat (5) tick();
        check("t4_no_deq", 64'(deq_cnt[0] + deq_cnt[1]), 0);
        check("t4_fifo_kept", 64'(fq[0].size()), 3);
        fq[0].delete();

        // T5: port 1 FIFO held empty for the first 10 run cycles
        clear_stats();
        for (int i = 0; i < 8; i++) begin
            load(0, 4'h0, 32'h5000_0000 + i, 1);
            load(1, 4'h0, 32'h6000_0000 + i, 1);
        end
        @(negedge clk);
        hold[1] = 11;
        do_start(10'd8, 1'b0, 4'h0);
        got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (xfer_cnt[0] == 8) got = 1;
        end
        check("t5_p0_complete", 64'(got), 1);
        check("t5_busy_mid", 64'(busy), 1);
        check("t5_p1_pending", 64'(xfer_cnt[1] < 8), 1);
        tick();
        wait_done(60, dc);
        check("t5_p1_delay", 64'(first_deq[1] - first_deq[0]), 10);
        check("t5_xfer_p1", 64'(xfer_cnt[1]), 8);

        check("sb_empty_p0", 64'(exp_q[0].size()), 0);
        check("sb_empty_p1", 64'(exp_q[1].size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
